// File: rtl/count_seq_monitor_if.sv
// Bundle between an up-counter source and count_seq_monitor.
// The source drives the count and clear; the monitor drives back lock, wrap and fault status.
`timescale 1ns/1ps
interface count_seq_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  Q_IN;
  logic              CLR;
  logic              LOCKED;
  logic              WRAP;
  logic [WRAP_W-1:0] WRAP_CNT;
  logic              ERR;
  logic [WIDTH-1:0]  ERR_EXP;
  logic [WIDTH-1:0]  ERR_GOT;

  modport master (
    output Q_IN, CLR,
    input  LOCKED, WRAP, WRAP_CNT, ERR, ERR_EXP, ERR_GOT
  );

  modport slave (
    input  Q_IN, CLR,
    output LOCKED, WRAP, WRAP_CNT, ERR, ERR_EXP, ERR_GOT
  );
endinterface

// File: rtl/count_seq_monitor.sv
// Checks that an upstream free-running counter advances by exactly +1 per clock,
// locks after LOCK_CNT good steps, counts wraps while locked and latches the first fault.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | just out of reset; next edge only captures the count
// ST_SYNC   | counting consecutive good steps toward lock
// ST_LOCKED | sequence trusted; wraps pulsed and counted
// ST_FAULT  | first mismatch latched; holds until CLR or reset
`timescale 1ns/1ps
module count_seq_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int WRAP_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  count_seq_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [4:0] LOCK_TGT = 5'(LOCK_CNT);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  prev, prev_nxt;
  logic [3:0]        good_cnt, good_nxt;
  logic              locked_r, locked_nxt;
  logic              wrap_r, wrap_nxt;
  logic [WRAP_W-1:0] wrap_cnt, wrap_cnt_nxt;
  logic              err, err_nxt;
  logic [WIDTH-1:0]  err_exp, exp_nxt;
  logic [WIDTH-1:0]  err_got, got_nxt;

  logic [WIDTH-1:0]  expected;
  logic              match;
  logic              is_wrap;
  logic [4:0]        good_inc;

  assign expected = prev + WIDTH'(1);
  assign match    = (mon.Q_IN == expected);
  assign is_wrap  = (&prev) && (mon.Q_IN == '0);
  assign good_inc = {1'b0, good_cnt} + 5'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      prev     <= '0;
      good_cnt <= '0;
      locked_r <= 1'b0;
      wrap_r   <= 1'b0;
      wrap_cnt <= '0;
      err      <= 1'b0;
      err_exp  <= '0;
      err_got  <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      good_cnt <= good_nxt;
      locked_r <= locked_nxt;
      wrap_r   <= wrap_nxt;
      wrap_cnt <= wrap_cnt_nxt;
      err      <= err_nxt;
      err_exp  <= exp_nxt;
      err_got  <= got_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    prev_nxt     = mon.Q_IN;
    good_nxt     = good_cnt;
    wrap_nxt     = 1'b0;
    wrap_cnt_nxt = wrap_cnt;
    err_nxt      = err;
    exp_nxt      = err_exp;
    got_nxt      = err_got;

    // CLR is deliberately ignored in IDLE so the first capture always happens
    if (state == ST_IDLE) begin
      state_nxt = ST_SYNC;
      good_nxt  = '0;
    end else if (mon.CLR) begin
      state_nxt    = ST_SYNC;
      good_nxt     = '0;
      wrap_cnt_nxt = '0;
      err_nxt      = 1'b0;
      exp_nxt      = '0;
      got_nxt      = '0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (!match) begin
            good_nxt = '0;
          end else if (good_inc == LOCK_TGT) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good_inc[3:0];
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            state_nxt = ST_FAULT;
            err_nxt   = 1'b1;
            exp_nxt   = expected;
            got_nxt   = mon.Q_IN;
          end else if (is_wrap) begin
            wrap_nxt = 1'b1;
            if (!(&wrap_cnt)) wrap_cnt_nxt = wrap_cnt + WRAP_W'(1);
          end
        end
        default: ;
      endcase
    end

    locked_nxt = (state_nxt == ST_LOCKED);
  end

  assign mon.LOCKED   = locked_r;
  assign mon.WRAP     = wrap_r;
  assign mon.WRAP_CNT = wrap_cnt;
  assign mon.ERR      = err;
  assign mon.ERR_EXP  = err_exp;
  assign mon.ERR_GOT  = err_got;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor: a behavioural model queues expected status per
// driven count; a second instance watches a real 4-bit counter, a third uses LOCK_CNT=1.
`timescale 1ns/1ps
module tb_count_seq_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk2 = 1'b0;
  logic rst2 = 1'b1;
  logic [3:0] cnt2;

  always #5 clk = ~clk;
  always #1 clk2 = ~clk2;

  count_seq_monitor_if #(.WIDTH(4), .WRAP_W(8)) bus ();
  count_seq_monitor_if #(.WIDTH(4), .WRAP_W(2)) bus2 ();
  count_seq_monitor_if #(.WIDTH(4), .WRAP_W(8)) bus3 ();

  count_seq_monitor #(.WIDTH(4), .LOCK_CNT(4), .WRAP_W(8)) dut  (.CLK(clk),  .RST(rst),  .mon(bus.slave));
  count_seq_monitor #(.WIDTH(4), .LOCK_CNT(4), .WRAP_W(2)) dut2 (.CLK(clk2), .RST(rst2), .mon(bus2.slave));
  count_seq_monitor #(.WIDTH(4), .LOCK_CNT(1), .WRAP_W(8)) dut3 (.CLK(clk),  .RST(rst),  .mon(bus3.slave));

  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) cnt2 <= 4'd0;
    else      cnt2 <= cnt2 + 4'd1;
  end

  assign bus2.Q_IN = cnt2;
  assign bus2.CLR  = 1'b0;
  assign bus3.Q_IN = bus.Q_IN;
  assign bus3.CLR  = bus.CLR;

  typedef struct {
    logic       locked;
    logic       wrap;
    logic [7:0] cnt;
    logic       err;
    logic [3:0] exp;
    logic [3:0] got;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // model state: 0 idle, 1 sync, 2 locked, 3 fault
  int         m_state;
  logic [3:0] m_prev;
  int         m_good;
  logic       m_wrap;
  int         m_cnt;
  logic       m_err;
  logic [3:0] m_exp, m_got;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 4'd0; m_good = 0; m_wrap = 1'b0;
    m_cnt = 0; m_err = 1'b0; m_exp = 4'd0; m_got = 4'd0;
    sbq.delete();
  endtask

  task automatic step(input logic [3:0] q, input logic c);
    exp_t e;
    logic [3:0] ev;
    bus.Q_IN = q;
    bus.CLR  = c;
    m_wrap = 1'b0;
    ev = m_prev + 4'd1;
    if (m_state == 0) begin
      m_state = 1; m_good = 0;
    end else if (c) begin
      m_state = 1; m_good = 0; m_cnt = 0; m_err = 1'b0; m_exp = 4'd0; m_got = 4'd0;
    end else if (m_state == 1) begin
      if (q == ev) begin
        m_good = m_good + 1;
        if (m_good == 4) begin m_state = 2; m_good = 0; end
      end else begin
        m_good = 0;
      end
    end else if (m_state == 2) begin
      if (q != ev) begin
        m_state = 3; m_err = 1'b1; m_exp = ev; m_got = q;
      end else if (m_prev == 4'hF) begin
        m_wrap = 1'b1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
    m_prev = q;
    e.locked = (m_state == 2);
    e.wrap = m_wrap;
    e.cnt = 8'(m_cnt);
    e.err = m_err;
    e.exp = m_exp;
    e.got = m_got;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_locked",   32'(bus.LOCKED),   32'(e.locked));
    chk("sb_wrap",     32'(bus.WRAP),     32'(e.wrap));
    chk("sb_wrap_cnt", 32'(bus.WRAP_CNT), 32'(e.cnt));
    chk("sb_err",      32'(bus.ERR),      32'(e.err));
    chk("sb_err_exp",  32'(bus.ERR_EXP),  32'(e.exp));
    chk("sb_err_got",  32'(bus.ERR_GOT),  32'(e.got));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},   32'(bus.LOCKED),   32'd0);
    chk({tag, "_wrap"},     32'(bus.WRAP),     32'd0);
    chk({tag, "_wrap_cnt"}, 32'(bus.WRAP_CNT), 32'd0);
    chk({tag, "_err"},      32'(bus.ERR),      32'd0);
    chk({tag, "_err_exp"},  32'(bus.ERR_EXP),  32'd0);
    chk({tag, "_err_got"},  32'(bus.ERR_GOT),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    bus.Q_IN = 4'd0;
    bus.CLR  = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    rst = 1'b0;

    // lock from 0..4
    step(4'd0, 1'b0);
    step(4'd1, 1'b0);
    chk("lock1_dut3", 32'(bus3.LOCKED), 32'd1);
    chk("not_yet_locked", 32'(bus.LOCKED), 32'd0);
    for (int v = 2; v <= 4; v++) step(4'(v), 1'b0);
    chk("lock_after_4", 32'(bus.LOCKED), 32'd1);
    chk("lock_err", 32'(bus.ERR), 32'd0);
    chk("lock_wrap_cnt", 32'(bus.WRAP_CNT), 32'd0);

    // first wrap
    for (int v = 5; v <= 15; v++) step(4'(v), 1'b0);
    step(4'd0, 1'b0);
    chk("wrap_pulse", 32'(bus.WRAP), 32'd1);
    chk("wrap_cnt1", 32'(bus.WRAP_CNT), 32'd1);
    step(4'd1, 1'b0);
    chk("wrap_one_cycle", 32'(bus.WRAP), 32'd0);
    chk("wrap_still_locked", 32'(bus.LOCKED), 32'd1);

    // fault at 9 (expected 7), second mismatch at 10 must not overwrite
    for (int v = 2; v <= 6; v++) step(4'(v), 1'b0);
    step(4'd9, 1'b0);
    chk("fault_err", 32'(bus.ERR), 32'd1);
    chk("fault_exp", 32'(bus.ERR_EXP), 32'd7);
    chk("fault_got", 32'(bus.ERR_GOT), 32'd9);
    chk("fault_unlock", 32'(bus.LOCKED), 32'd0);
    step(4'd10, 1'b0);
    chk("fault_sticky_exp", 32'(bus.ERR_EXP), 32'd7);
    chk("fault_sticky_got", 32'(bus.ERR_GOT), 32'd9);

    // clear from fault, then progress reset by a mismatch at 7
    step(4'd15, 1'b1);
    chk("clr_err", 32'(bus.ERR), 32'd0);
    chk("clr_wrap_cnt", 32'(bus.WRAP_CNT), 32'd0);
    chk("clr_locked", 32'(bus.LOCKED), 32'd0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd2, 1'b0);
    step(4'd7, 1'b0); step(4'd8, 1'b0); step(4'd9, 1'b0); step(4'd10, 1'b0);
    chk("relock_not_early", 32'(bus.LOCKED), 32'd0);
    step(4'd11, 1'b0);
    chk("relock_at_11", 32'(bus.LOCKED), 32'd1);
    chk("relock_err", 32'(bus.ERR), 32'd0);

    // clear while locked beats the compare; wrap on the locking edge is not counted
    step(4'd12, 1'b1);
    for (int v = 13; v <= 15; v++) step(4'(v), 1'b0);
    step(4'd0, 1'b0);
    chk("lock_edge_no_wrap", 32'(bus.WRAP), 32'd0);
    step(4'd1, 1'b0);

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    bus.CLR = 1'b1;
    #1;
    rst = 1'b0;
    step(4'd3, 1'b1);
    for (int v = 4; v <= 7; v++) step(4'(v), 1'b0);
    chk("idle_clr_ignored_lock", 32'(bus.LOCKED), 32'd1);

    // real counter, 2-bit saturating wrap count
    @(posedge clk2);
    #0.5 rst2 = 1'b1;
    #1   rst2 = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk2);
      #0.5;
      if (i == 4)  chk("ctr_not_locked_4", 32'(bus2.LOCKED), 32'd0);
      if (i == 5)  chk("ctr_locked_5", 32'(bus2.LOCKED), 32'd1);
      if (i == 48) chk("ctr_wrap_cnt_2", 32'(bus2.WRAP_CNT), 32'd2);
      if (i == 49) chk("ctr_wrap_cnt_3", 32'(bus2.WRAP_CNT), 32'd3);
      if (bus2.WRAP) pulses++;
    end
    chk("ctr_wrap_sat", 32'(bus2.WRAP_CNT), 32'd3);
    chk("ctr_pulses", 32'(pulses), 32'd4);
    chk("ctr_err", 32'(bus2.ERR), 32'd0);
    chk("ctr_locked_end", 32'(bus2.LOCKED), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream checker for the free-running 4-bit up-counter stage (`top`, output Q).
- Samples the counter value every clock and confirms it advances by exactly +1 modulo 2^WIDTH.
- Locks after a run of good steps, counts wrap-arounds and latches the first sequence fault for status/debug logic.
- Sits on the same clock as the counter, directly after it.

Parameters:
- WIDTH, 4, bit width of the monitored count.
- LOCK_CNT, 4, consecutive correct increments required to enter LOCKED (range 1..15).
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- Q_IN  input  WIDTH  count value from the upstream counter.
- CLR  input  1  synchronous clear of fault and wrap status.
- LOCKED  output  1  high while in LOCKED state.
- WRAP  output  1  one-cycle pulse per detected wrap (all-ones to 0) while LOCKED.
- WRAP_CNT  output  WRAP_W  number of wraps seen while LOCKED, saturating.
- ERR  output  1  sticky fault flag.
- ERR_EXP  output  WIDTH  expected value at the first fault.
- ERR_GOT  output  WIDTH  received value at the first fault.

Behaviour:
- One clock domain: CLK. Reset is asynchronous and active-high on RST.
- Reset (async, immediate, no clock needed):
  - state=IDLE, prev=0, good_cnt=0.
  - All outputs 0.
- Every state and counter register and every output is registered. Each compare happens at a rising edge and its result is visible immediately after that edge (latency 0 cycles from sampling edge).
- expected = prev + 1, truncated to WIDTH bits, so all-ones + 1 = 0.
- prev <= Q_IN on every edge in every state.
- IDLE: first edge after reset release captures prev only, then goes to SYNC with good_cnt=0.
- SYNC:
  - Q_IN==expected: good_cnt++. When the increment reaches LOCK_CNT, go to LOCKED on that same edge and clear good_cnt.
  - Mismatch: good_cnt=0, stay in SYNC, ERR unchanged.
  - Wraps in SYNC are neither pulsed nor counted.
- LOCKED:
  - Match with prev=all-ones and Q_IN=0: WRAP=1 for exactly one cycle, WRAP_CNT++ saturating at 2^WRAP_W-1.
  - Mismatch: go to FAULT, ERR=1, ERR_EXP=expected, ERR_GOT=Q_IN, LOCKED=0.
- FAULT:
  - Sticky. Further mismatches do not overwrite ERR_EXP/ERR_GOT.
  - No WRAP pulses in FAULT.
- CLR (synchronous, any state except IDLE, has priority over the compare on that edge):
  - ERR=0, ERR_EXP=0, ERR_GOT=0, WRAP_CNT=0, WRAP=0, good_cnt=0.
  - state=SYNC, prev<=Q_IN.
- CLR in IDLE is ignored; the IDLE→SYNC capture proceeds normally.
- LOCKED output equals (state==LOCKED).
- Reset asserted mid-operation in any state returns to IDLE immediately. Any partial lock progress and latched fault are discarded.
- LOCK_CNT=1: a single correct step locks.

Test Plan:
- Reset, then drive Q_IN=0,1,2,3,4 on successive edges (LOCK_CNT=4) → LOCKED=1 after the edge sampling 4; ERR=0, WRAP_CNT=0.
- Continue 5..15 then 0 → WRAP pulses high for exactly one cycle after the edge sampling 0; WRAP_CNT=1; LOCKED stays 1.
- While LOCKED, drive 5,6,9,10 → after the edge sampling 9: ERR=1, ERR_EXP=7, ERR_GOT=9, LOCKED=0. After sampling 10, ERR_EXP/ERR_GOT are unchanged.
- Unlocked, drive 0,1,2,7,8,9,10,11 → mismatch at 7 resets progress; LOCKED=1 only after sampling 11; ERR stays 0.
- Connect the real 4-bit counter (2 ns clock, RST high 1 ns) with WRAP_W=2 → locked after five edges; WRAP_CNT saturates at 3 after the third counted wrap; no ERR.
- From FAULT, pulse CLR for one cycle → ERR=0, WRAP_CNT=0, state SYNC; relock after 4 good steps.
- Assert RST between clock edges while LOCKED → all outputs 0 immediately, without waiting for a clock edge.
